sbox_pipe: RTL and testbench
============================

# sbox_pipe

Pipelined, multi-lane AES S-box engine with valid/ready flow control, a per-transaction forward/inverse mode bit and a full scan chain through every pipeline flop. Each transaction substitutes `LANES` bytes in parallel, computing either SubBytes or InvSubBytes. The block sits between a round controller (upstream) and the ShiftRows/MixColumns datapath (downstream). It supersedes the single-byte, forward-only combinational S-box.

## Interface
Parameters:
- `LANES`, 4: bytes substituted per transaction, 1..16.
- `STAGES`, 2: pipeline register stages, 1..4.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input transaction present.
- `in_ready` out 1: block accepts the transaction this cycle.
- `in_inv` in 1: 0 selects forward S-box, 1 selects inverse S-box.
- `in_data` in 8*LANES: lane k on bits [8k+7:8k].
- `out_valid` out 1: result present.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out 8*LANES: substituted bytes, same lane order.
- `scan_en` in 1: scan shift mode.
- `scand` in 1: scan data in.
- `scanq` out 1: scan data out.

## Operation
- Pipeline registers: stage i (1..STAGES) holds `v[i]`, `inv[i]` and `d[i]` (8*LANES bits).
- Substitution logic placement:
  - STAGES=1: the logic sits between the input ports and stage 1.
  - STAGES≥2: stage 1 captures the raw input, and the logic sits between stage STAGES-1 and stage STAGES. All other stages are plain delay.
- S-box function:
  - Forward = GF(2^8) multiplicative inverse (modulus 0x11B, 0 maps to 0), then the affine transform with constant 0x63.
  - Inverse = inverse affine transform (constant 0x05), then the GF inverse.
  - Each lane is an independent instance. The result must equal the FIPS-197 tables for all 256 values in both modes.
- Global stall:
  - `adv = !v[STAGES] || out_ready`, and `in_ready = adv` (combinational).
  - When `adv` is 1, every stage loads from its predecessor; stage 1 loads `in_valid`, `in_inv` and `in_data`.
  - When `adv` is 0, all stages hold.
  - Bubbles are not squeezed out.
- Data and mode registers of a stage with `v=0` still load, but their content is don't-care.
- Outputs are taken directly from the last stage:
  - `out_valid = v[STAGES]`
  - `out_data = d[STAGES]`
- Scan mode (`scan_en=1`):
  - Handshakes are ignored. `in_ready` is forced to 0, and `out_valid` reflects `v[STAGES]` unchanged.
  - Every pipeline flop shifts one position per clock. Chain order: `scand` → `v[1]`, `inv[1]`, `d[1]` bit 0..MSB, then `v[2]`, and so on.
  - `scanq` is the MSB of `d[STAGES]`.
  - Chain length is STAGES*(8*LANES+2).
  - When `scan_en=0`, `scanq` still drives that same flop.
- `rst`:
  - Asynchronously clears all `v`, `inv` and `d` flops to 0.
  - Reset values: `out_valid`=0, `out_data`=0, `scanq`=0, and `in_ready`=1 (unless `scan_en`=1).
  - Reset mid-stream drops all in-flight transactions; nothing is emitted afterward for them.

## Timing
- Latency: STAGES cycles from accepted input (`in_valid && in_ready` at edge t) to `out_valid` high after edge t+STAGES-1, assuming no stalls.
- Throughput: one transaction per cycle with `out_ready` held high.
- Stall:
  - `out_valid && !out_ready` holds `out_data` stable, and `in_ready` drops in the same cycle.
  - A transfer on both sides in the same cycle is legal and keeps full throughput.
- Mode switches are allowed every transaction without bubbles. Each transaction carries its own `inv` bit.
- `in_ready` and `out_valid` have no combinational dependence on `in_valid`.
- Releasing `rst` takes effect at the next rising edge of `clk`. No input is captured at the edge where `rst` is high.

## Test plan
- **Forward, LANES=4, STAGES=2, out_ready=1:**
  - Stimulus: `in_data`=0xFF53_0100, `in_inv`=0.
  - Required: `out_data`=0x16ED_7C63, with `out_valid` high exactly 2 cycles after acceptance.
- **Inverse and exhaustive sweep:**
  - Stimulus: `in_inv`=1, `in_data`=0x16ED_7C63.
  - Required: 0xFF53_0100 returned.
  - Sweep all 256 values per lane in both modes against a reference table, with `in_inv` alternating every transaction. Required: zero mismatches.
- **Backpressure:**
  - Stimulus: stream 10 transactions while `out_ready` is low for cycles 3..6.
  - Required: `out_data` is held stable while stalled, `in_ready`=0 during the stall, and all 10 results arrive in order with none lost or duplicated.
- **Reset mid-stream:**
  - Stimulus: assert `rst` asynchronously (between edges) with 2 transactions in flight.
  - Required: `out_valid` and `out_data` go to 0 immediately, and no stale result appears after release.
- **Scan:**
  - Stimulus: with `scan_en`=1, shift in a 0x1, 0x0 pattern of length STAGES*(8*LANES+2) and then shift it out.
  - Required: `scanq` reproduces the pattern delayed by the chain length (68 cycles for the defaults).
- **Parameter corners:**
  - Run scenario 1 at LANES=1/STAGES=1 and at LANES=16/STAGES=4.
  - Required: latency is 1 and 4 cycles respectively, with correct bytes in every lane.

Source files
------------

// File: rtl/sbox_pipe.sv
// sbox_pipe: multi-lane AES S-box (forward/inverse) behind a stallable
// pipeline. Every pipeline flop sits on one scan chain.
// Each stage is stored as {d, inv, v}, so the flattened register vector is
// the scan chain itself: bit 0 is v[1], the top bit is the MSB of d[STAGES].

// One byte lane: the same GF(2^8) inverter serves both directions; only the
// affine step moves to the other side of it.
module sbox_lane (
  input  logic [7:0] i_d,
  input  logic       i_inv,
  output logic [7:0] o_q
);
  // GF(2^8) multiply, reduction polynomial 0x11B
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  // a^254 == a^-1 for a != 0, and 0 for a == 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq, acc;
    sq  = a;
    acc = 8'h01;
    for (int i = 0; i < 7; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] aff_fwd(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]}
             ^ {a[3:0], a[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] aff_inv(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
  endfunction

  logic [7:0] w_pre, w_gi;

  assign w_pre = i_inv ? aff_inv(i_d) : i_d;
  assign w_gi  = gf_inv(w_pre);
  assign o_q   = i_inv ? w_gi : aff_fwd(w_gi);
endmodule

module sbox_pipe #(
  parameter int LANES  = 4,
  parameter int STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  input  logic               scan_en,
  input  logic               scand,
  output logic               scanq
);
  localparam int DW = 8 * LANES;
  localparam int W  = DW + 2;       // one stage: {d, inv, v}
  localparam int N  = STAGES * W;   // scan chain length

  logic [STAGES-1:0][W-1:0] r_st;
  logic [STAGES-1:0][W-1:0] w_nxt;
  logic [N-1:0]             w_flat, w_shift;
  logic [W-1:0]             w_src;   // stage feeding the substitution logic
  logic [DW-1:0]            w_sub;
  logic                     w_adv;

  assign w_flat  = r_st;
  assign w_shift = {w_flat[N-2:0], scand};

  // Global stall: everything moves only when the last stage can drain
  assign w_adv     = !r_st[STAGES-1][0] || out_ready;
  assign in_ready  = w_adv && !scan_en;
  assign out_valid = r_st[STAGES-1][0];
  assign out_data  = r_st[STAGES-1][W-1:2];
  assign scanq     = r_st[STAGES-1][W-1];

  // Single stage substitutes on the way in; deeper pipes register the raw
  // input first and substitute into the last stage.
  generate
    if (STAGES == 1) begin : g_src_in
      assign w_src = {in_data, in_inv, in_valid};
    end else begin : g_src_reg
      assign w_src = r_st[STAGES-2];
    end
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      sbox_lane u_lane (
        .i_d   (w_src[2+8*k +: 8]),
        .i_inv (w_src[1]),
        .o_q   (w_sub[8*k +: 8])
      );
    end
  endgenerate

  // Next-stage values in normal mode: plain shift, last stage gets the S-box output
  always_comb begin
    w_nxt[0] = {in_data, in_inv, in_valid};
    for (int s = 1; s < STAGES; s++) w_nxt[s] = r_st[s-1];
    w_nxt[STAGES-1] = {w_sub, w_src[1:0]};
  end

  // Pipeline registers: scan shift overrides, otherwise advance or hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_st <= '0;
    else if (scan_en) r_st <= w_shift;
    else if (w_adv)   r_st <= w_nxt;
  end
endmodule

// File: tb/tb_sbox_pipe.sv
// tb_sbox_pipe: scoreboard bench for sbox_pipe at defaults, plus two corner
// instances (1 lane / 1 stage, 16 lanes / 4 stages) for latency and lane checks.
module tb_sbox_pipe;
  localparam int L = 4;
  localparam int S = 2;
  localparam int W = 8 * L + 2;
  localparam int N = S * W;

  typedef struct {
    logic [31:0] d;
    int          t;
  } sb_t;

  logic        clk, rst;
  logic        in_valid, in_ready, in_inv, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic        scan_en, scand, scanq;

  logic         c1_in_valid, c1_in_ready, c1_out_valid, c1_scanq;
  logic [7:0]   c1_in_data, c1_out_data;
  logic         c4_in_valid, c4_in_ready, c4_out_valid, c4_scanq;
  logic [127:0] c4_in_data, c4_out_data;

  int   n_cmp = 0, n_err = 0, cyc = 0;
  bit   lat_on = 0;
  sb_t  sb[$];

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};
  logic [7:0] isbox [256];

  sbox_pipe #(.LANES(L), .STAGES(S)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .scan_en(scan_en), .scand(scand), .scanq(scanq));

  sbox_pipe #(.LANES(1), .STAGES(1)) dut_c1 (
    .clk(clk), .rst(rst), .in_valid(c1_in_valid), .in_ready(c1_in_ready), .in_inv(1'b0),
    .in_data(c1_in_data), .out_valid(c1_out_valid), .out_ready(1'b1), .out_data(c1_out_data),
    .scan_en(1'b0), .scand(1'b0), .scanq(c1_scanq));

  sbox_pipe #(.LANES(16), .STAGES(4)) dut_c4 (
    .clk(clk), .rst(rst), .in_valid(c4_in_valid), .in_ready(c4_in_ready), .in_inv(1'b0),
    .in_data(c4_in_data), .out_valid(c4_out_valid), .out_ready(1'b1), .out_data(c4_out_data),
    .scan_en(1'b0), .scand(1'b0), .scanq(c4_scanq));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref4(input logic [31:0] d, input logic inv);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = inv ? isbox[d[8*k +: 8]] : sbox[d[8*k +: 8]];
    return r;
  endfunction

  // Drive one transaction; the expected result joins the scoreboard on acceptance
  task automatic send(input logic [31:0] d, input logic inv, input logic [31:0] e);
    int  n;
    sb_t x;
    in_valid = 1'b1; in_data = d; in_inv = inv; n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) chk("accept_timeout", 128'(in_ready), 128'd1);
    else begin x.d = e; x.t = cyc + 1; sb.push_back(x); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    chk("drain", 128'(sb.size()), 128'd0);
    #1;
  endtask

  // Output monitor: pops on every transfer, checks data, latency, stall hold
  bit          stalled = 0;
  logic [31:0] held;
  always @(negedge clk) begin
    if (rst || scan_en) stalled = 0;
    else begin
      if (stalled) begin
        chk("hold_valid", 128'(out_valid), 128'd1);
        chk("hold_data", 128'(out_data), 128'(held));
      end
      if (out_valid && !out_ready) chk("stall_in_ready", 128'(in_ready), 128'd0);
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("unexpected_out", 128'(out_valid), 128'd0);
        else begin
          sb_t e;
          e = sb.pop_front();
          chk("data", 128'(out_data), 128'(e.d));
          if (lat_on) chk("latency", 128'(cyc - e.t + 1), 128'(S));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, t0;
    logic [31:0] d;
    logic [N-1:0] pat;
    for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);
    rst = 1; in_valid = 0; in_inv = 0; in_data = 0; out_ready = 1; scan_en = 0; scand = 0;
    c1_in_valid = 0; c1_in_data = 0; c4_in_valid = 0; c4_in_data = 0;

    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", 128'(out_data), 128'd0);
    chk("rst_scanq", 128'(scanq), 128'd0);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    @(posedge clk); #1 rst = 0;
    repeat (2) @(posedge clk);
    #1;

    // Corners: 1 lane / 1 stage, then 16 lanes / 4 stages
    c1_in_valid = 1; c1_in_data = 8'h53;
    @(posedge clk); #1 c1_in_valid = 0; n = 1;
    while (!c1_out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("c1_latency", 128'(n), 128'd1);
    chk("c1_data", 128'(c1_out_data), 128'hed);
    c4_in_valid = 1; c4_in_data = 128'hC0B0A090_80706050_40302010_FF530100;
    @(posedge clk); #1 c4_in_valid = 0; n = 1;
    while (!c4_out_valid && n < 10) begin @(posedge clk); #1; n++; end
    chk("c4_latency", 128'(n), 128'd4);
    chk("c4_data", c4_out_data, 128'hBAE7E060_CD51D053_0904B7CA_16ED7C63);

    // Directed forward / inverse with latency checking
    lat_on = 1;
    send(32'hFF53_0100, 1'b0, 32'h16ED_7C63);
    send(32'h16ED_7C63, 1'b1, 32'hFF53_0100);
    drain();

    // Sweep: every byte value in every lane, both modes, mode alternating
    t0 = cyc;
    for (int j = 0; j < 512; j++) begin
      for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'((j >> 1) + 37 * k);
      send(d, j[0], ref4(d, j[0]));
    end
    chk("throughput", 128'(cyc - t0), 128'd512);
    drain();

    // Backpressure: 10 transactions, out_ready low in cycles 3..6
    lat_on = 0;
    fork
      for (int i = 0; i < 10; i++) begin
        d = {8'(i * 17), 8'(i * 3 + 1), 8'(255 - i), 8'(i + 100)};
        send(d, (i % 3) == 0, ref4(d, (i % 3) == 0));
      end
      begin
        for (int c = 0; c < 16; c++) begin
          out_ready = !(c >= 3 && c <= 6);
          @(posedge clk); #1;
        end
        out_ready = 1;
      end
    join
    drain();

    // Asynchronous reset with two transactions in flight
    send(32'h0011_2233, 1'b0, ref4(32'h0011_2233, 1'b0));
    send(32'h4455_6677, 1'b1, ref4(32'h4455_6677, 1'b1));
    #1 chk("pre_rst_valid", 128'(out_valid), 128'd1);
    #1 rst = 1; sb.delete();
    #1;
    chk("async_rst_valid", 128'(out_valid), 128'd0);
    chk("async_rst_data", 128'(out_data), 128'd0);
    in_valid = 1; in_data = 32'hA5A5_A5A5;
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("no_stale_out", 128'(out_valid), 128'd0);
    end

    // Scan: shift a pattern through the full chain and back out
    pat = '0;
    for (int i = 2; i < N; i++) pat[i] = 1'($urandom_range(1, 0));
    pat[0] = 1'b1; pat[1] = 1'b0;
    scan_en = 1;
    #1 chk("scan_in_ready", 128'(in_ready), 128'd0);
    for (int i = 0; i < 2 * N - 1; i++) begin
      scand = (i < N) ? pat[i] : 1'b0;
      @(posedge clk); #1;
      if (i >= N - 1) chk("scanq", 128'(scanq), 128'(pat[i-N+1]));
      if (i >= (S - 1) * W && i - (S - 1) * W < N)
        chk("scan_out_valid", 128'(out_valid), 128'(pat[i-(S-1)*W]));
    end
    scan_en = 0; scand = 0; rst = 1;
    #2;
    chk("post_scan_rst_valid", 128'(out_valid), 128'd0);
    chk("post_scan_rst_scanq", 128'(scanq), 128'd0);
    chk("post_scan_rst_in_ready", 128'(in_ready), 128'd1);
    @(negedge clk); rst = 0;
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
